// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and parity constants shared by the UART TX/RX blocks
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  function automatic logic parity_bit(input logic [8:0] d, input logic odd);
    return ^d ^ odd;
  endfunction
endpackage

// File: rtl/uart_tx_framer_baud_gen.sv
// uart_baud_gen: counts 0..CLKS_PER_BIT-1 and strobes bit_tick on the wrap; held at 0 by clear
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);
  logic [CNT_W-1:0] cnt;
  assign bit_tick = !clear && cnt == CNT_W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) cnt <= (rst || clear || bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises one latched byte as start, data LSB-first, optional parity and 1/2 stop bits
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int BW = $clog2(DATA_BITS + 1);
  uart_state_e state, state_n;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0] bit_cnt;
  logic stop_cnt, par_en_q, par_q, two_stop_q;
  logic bit_tick, accept, last_bit, last_stop, tx_d, done_d;
  assign tx_ready  = state == ST_IDLE;
  assign busy      = !tx_ready;
  assign accept    = tx_valid && tx_ready;
  assign last_bit  = bit_cnt == BW'(DATA_BITS - 1);
  assign last_stop = stop_cnt == two_stop_q;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_baud (
    .clk(clk), .rst(rst), .clear(state == ST_IDLE), .bit_tick(bit_tick)
  );
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   state_n = accept ? ST_START : ST_IDLE;
      ST_START:  state_n = bit_tick ? ST_DATA : ST_START;
      ST_DATA:   state_n = !(bit_tick && last_bit) ? ST_DATA : par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: state_n = bit_tick ? ST_STOP : ST_PARITY;
      ST_STOP:   state_n = (bit_tick && last_stop) ? ST_IDLE : ST_STOP;
      default:   state_n = ST_IDLE;
    endcase
    tx_d   = state == ST_START ? 1'b0 : state == ST_DATA ? shreg[0] : state == ST_PARITY ? par_q : 1'b1;
    done_d = state == ST_STOP && bit_tick && last_stop;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      state    <= state_n;
      tx       <= tx_d;
      tx_done  <= done_d;
      bit_cnt  <= state == ST_DATA ? (bit_tick ? bit_cnt + 1'b1 : bit_cnt) : '0;
      stop_cnt <= state == ST_STOP ? stop_cnt ^ bit_tick : 1'b0;
    end
  end
  // shadow copies make mid-frame input changes invisible to the current frame
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg      <= tx_data;
      par_en_q   <= parity_en;
      par_q      <= parity_bit(9'(tx_data), parity_odd == PARITY_ODD);
      two_stop_q <= two_stop;
    end else if (state == ST_DATA && bit_tick) begin
      shreg <= shreg >> 1;
    end
  end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed frames at CLKS_PER_BIT=4, DATA_BITS=8 with hand-computed bit patterns
module tb_uart_tx_framer;
  logic clk = 1'b0;
  logic rst, tx_valid, tx_ready, parity_en, parity_odd, two_stop, tx, busy, tx_done;
  logic [7:0] tx_data;
  int errors = 0;
  int checks = 0;
  uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .tx(tx), .busy(busy), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic pen, input logic podd, input logic two);
    @(negedge clk);
    check("ready before accept", tx_ready, 1);
    tx_data = d; parity_en = pen; parity_odd = podd; two_stop = two; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check("busy after accept", busy, 1);
  endtask
  // called #1 after the accept edge; bit i of exp is the i-th bit on the line
  task automatic frame(input string tag, input logic [11:0] exp, input int n, input bit perturb);
    for (int k = 0; k < 4 * n; k++) begin
      @(posedge clk); #1;
      check($sformatf("%s tx k=%0d", tag, k), tx, exp[k / 4]);
      check($sformatf("%s done k=%0d", tag, k), tx_done, k == 4 * n - 1);
      if (k < 4 * n - 1) check($sformatf("%s ready k=%0d", tag, k), tx_ready, 0);
      if (perturb && k == 10) begin
        tx_data = 8'hFF; parity_en = ~parity_en; parity_odd = ~parity_odd; two_stop = ~two_stop;
      end
    end
  endtask
  task automatic idle_after(input string tag);
    @(posedge clk); #1;
    check({tag, " idle tx"}, tx, 1);
    check({tag, " idle done"}, tx_done, 0);
    check({tag, " idle ready"}, tx_ready, 1);
  endtask
  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst tx", tx, 1);
    check("rst ready", tx_ready, 1);
    check("rst busy", busy, 0);
    check("rst done", tx_done, 0);
    @(negedge clk) rst = 1'b0;
    send(8'hA5, 0, 0, 0);
    frame("a5", {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 0);
    idle_after("a5");
    send(8'hA5, 1, 0, 0);
    frame("a5 even", {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 0);
    idle_after("a5 even");
    send(8'hA5, 1, 1, 0);
    frame("a5 odd", {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 0);
    idle_after("a5 odd");
    send(8'h00, 1, 1, 1);
    frame("00 2stop", {1'b1, 1'b1, 1'b1, 8'h00, 1'b0}, 12, 0);
    idle_after("00 2stop");
    send(8'h3C, 1, 0, 0);
    frame("shadow", {1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 1);
    idle_after("shadow");
    @(negedge clk);
    tx_data = 8'h3C; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'hC3;
    frame("b2b1", {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 0);
    check("b2b ready at done", tx_ready, 1);
    @(posedge clk); #1;
    check("b2b gap tx", tx, 1);
    check("b2b second accept", tx_ready, 0);
    tx_valid = 1'b0;
    frame("b2b2", {2'b00, 1'b1, 8'hC3, 1'b0}, 10, 0);
    idle_after("b2b2");
    send(8'h5A, 0, 0, 0);
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort tx k=%0d", k), tx, k < 4 ? 0 : 8'h5A >> (k / 4 - 1) & 1);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("abort tx", tx, 1);
    check("abort ready", tx_ready, 1);
    check("abort done", tx_done, 0);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      check($sformatf("post abort done k=%0d", k), tx_done, 0);
      check($sformatf("post abort tx k=%0d", k), tx, 1);
    end
    send(8'h81, 0, 0, 0);
    frame("81", {2'b00, 1'b1, 8'h81, 1'b0}, 10, 0);
    idle_after("81");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
